// File: rtl/pc_control.sv
// Program-counter unit for the single-cycle MIPS core: next-PC selection (jr > jump > branch > sequential),
// stall hold, return-address stack checking jr targets, and a taken-transfer counter.
module pc_control #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          RAS_DEPTH    = 4,
  parameter int          CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [15:0]                imm16,
  input  logic                       jump,
  input  logic                       link,
  input  logic [25:0]                target26,
  input  logic                       jr,
  input  logic [31:0]                jr_target,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic                       ras_miss,
  output logic                       jr_misalign,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic [CNT_W-1:0]           xfer_count
);

  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [PW-1:0]    PTR_ONE = 1;
  localparam logic [PW:0]      RC_ONE  = 1;
  localparam logic [PW:0]      RC_FULL = RAS_DEPTH;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_JR
  } sel_e;

  sel_e        sel;
  logic [31:0] next_pc;
  logic [31:0] br_offset;
  logic [31:0] jr_aligned;
  logic        do_push;
  logic        do_pop;
  logic        take;

  // Circular stack: wr_ptr is the next slot to write, so the top lives at wr_ptr-1 and a push
  // into a full stack naturally overwrites the oldest entry.
  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [31:0]   ras_top;

  assign pc_plus4 = pc + 32'd4;
  assign ras_top  = ras_mem[wr_ptr - PTR_ONE];

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    sel        = SEL_SEQ;
    br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
    jr_aligned = {jr_target[31:2], 2'b00};
    next_pc    = pc_plus4;

    if (jr)                sel = SEL_JR;
    else if (jump)         sel = SEL_JMP;
    else if (branch_taken) sel = SEL_BR;

    case (sel)
      SEL_BR:  next_pc = pc_plus4 + br_offset;
      SEL_JMP: next_pc = {pc_plus4[31:28], target26, 2'b00};
      SEL_JR:  next_pc = jr_aligned;
      default: next_pc = pc_plus4;
    endcase

    do_push = (sel == SEL_JMP) && link;
    do_pop  = (sel == SEL_JR);
    take    = (sel != SEL_SEQ);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_VECTOR;
      wr_ptr      <= '0;
      ras_count   <= '0;
      xfer_count  <= '0;
      ras_miss    <= 1'b0;
      jr_misalign <= 1'b0;
    end else begin
      ras_miss    <= 1'b0;
      jr_misalign <= 1'b0;
      if (!stall) begin
        pc <= next_pc;
        if (take) xfer_count <= xfer_count + CNT_ONE;
        if (do_push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (ras_count != RC_FULL) ras_count <= ras_count + RC_ONE;
        end else if (do_pop) begin
          ras_miss    <= (ras_count == '0) || (ras_top != jr_aligned);
          jr_misalign <= |jr_target[1:0];
          if (ras_count != '0) begin
            wr_ptr    <= wr_ptr - PTR_ONE;
            ras_count <= ras_count - RC_ONE;
          end
        end
      end
    end
  end

  // NOTE: stack storage is not reset; ras_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!stall && do_push) ras_mem[wr_ptr] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: expected outputs are queued as stimulus is driven and
// compared one cycle later, after the clock edge that produces them.
module tb_pc_control;

  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          DEPTH = 4;
  localparam int          CW    = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] imm16;
  logic        jump;
  logic        link;
  logic [25:0] target26;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ras_miss;
  logic        jr_misalign;
  logic [2:0]  ras_count;
  logic [CW-1:0] xfer_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [15:0] xfer;
    logic [2:0]  rc;
    logic        miss;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_control #(.RESET_VECTOR(RV), .RAS_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken), .imm16(imm16),
    .jump(jump), .link(link), .target26(target26), .jr(jr), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .ras_miss(ras_miss), .jr_misalign(jr_misalign),
    .ras_count(ras_count), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [15:0] imm, input logic jmp,
                       input logic lnk, input logic [25:0] t26, input logic jrv, input logic [31:0] jt);
    stall = st; branch_taken = br; imm16 = imm; jump = jmp;
    link = lnk; target26 = t26; jr = jrv; jr_target = jt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] p, input logic [15:0] x,
                          input logic [2:0] rc, input logic m, input logic mis);
    exp_t e;
    e.tag = tag; e.pc = p; e.xfer = x; e.rc = rc; e.miss = m; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: output observed with no queued expectation");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"},          pc,                  e.pc);
      check({e.tag, ".pc_plus4"},    pc_plus4,            e.pc + 32'd4);
      check({e.tag, ".xfer_count"},  32'(xfer_count),     32'(e.xfer));
      check({e.tag, ".ras_count"},   32'(ras_count),      32'(e.rc));
      check({e.tag, ".ras_miss"},    32'(ras_miss),       32'(e.miss));
      check({e.tag, ".jr_misalign"}, 32'(jr_misalign),    32'(e.mis));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", RV, 16'd0, 3'd0, 1'b0, 1'b0);
    compare_front();
    reset_n = 1'b1;

    // 1: sequential fetch from the reset vector
    for (int i = 1; i <= 4; i++) begin
      idle();
      push_exp($sformatf("seq%0d", i), RV + 32'(4 * i), 16'd0, 3'd0, 1'b0, 1'b0);
      tick();
    end

    // 2: countdown loop, backward branch at 0x0C
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 26'h3, 1'b0, 32'h0);
    push_exp("jmp_loop", 32'h0C, 16'd1, 3'd0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0);
      push_exp($sformatf("loop_br%0d", k), 32'h04, 16'(2 + k), 3'd0, 1'b0, 1'b0);
      tick();
      idle();
      push_exp($sformatf("loop_a%0d", k), 32'h08, 16'(2 + k), 3'd0, 1'b0, 1'b0);
      tick();
      push_exp($sformatf("loop_b%0d", k), 32'h0C, 16'(2 + k), 3'd0, 1'b0, 1'b0);
      tick();
    end
    push_exp("loop_exit", 32'h10, 16'd5, 3'd0, 1'b0, 1'b0);
    tick();

    // 3: jal then matching jr
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 26'h2, 1'b0, 32'h0);
    push_exp("jmp_08", 32'h08, 16'd6, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 26'h40, 1'b0, 32'h0);
    push_exp("jal", 32'h100, 16'd7, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h0C);
    push_exp("jr_ret", 32'h0C, 16'd8, 3'd0, 1'b0, 1'b0);
    tick();
    idle();
    push_exp("after_jr", 32'h10, 16'd8, 3'd0, 1'b0, 1'b0);
    tick();

    // 4: five nested jal overflow a 4-deep stack, then five returns
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 26'((i + 1) * 32'h40), 1'b0, 32'h0);
      push_exp($sformatf("nest_jal%0d", i), 32'((i + 1) * 32'h100), 16'(9 + i),
               (i < 3) ? 3'(i + 1) : 3'd4, 1'b0, 1'b0);
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h404 - 32'(j * 32'h100));
      push_exp($sformatf("nest_jr%0d", j), 32'h404 - 32'(j * 32'h100), 16'(14 + j),
               3'(3 - j), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h14);
    push_exp("nest_jr_empty", 32'h14, 16'd18, 3'd0, 1'b1, 1'b0);
    tick();
    idle();
    push_exp("miss_clear", 32'h18, 16'd18, 3'd0, 1'b0, 1'b0);
    tick();

    // 5: jr wins over jal and branch; misaligned target; pop of empty stack misses
    drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b1, 26'h3FF, 1'b1, 32'h202);
    push_exp("prio", 32'h200, 16'd19, 3'd0, 1'b1, 1'b1);
    tick();
    idle();
    push_exp("prio_clear", 32'h204, 16'd19, 3'd0, 1'b0, 1'b0);
    tick();

    // sequential wrap at the top of the address space
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    push_exp("jr_top", 32'hFFFF_FFFC, 16'd20, 3'd0, 1'b1, 1'b0);
    tick();
    idle();
    push_exp("wrap", 32'h0, 16'd20, 3'd0, 1'b0, 1'b0);
    tick();

    // 6: stalled jal, then released; stall clears pulses; reset mid-sequence
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 26'h80, 1'b0, 32'h0);
      push_exp($sformatf("stall%0d", i), 32'h0, 16'd20, 3'd0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 26'h80, 1'b0, 32'h0);
    push_exp("jal_release", 32'h200, 16'd21, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h005);
    push_exp("jr_mis", 32'h004, 16'd22, 3'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h007);
    push_exp("stall_clears", 32'h004, 16'd22, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 26'h80, 1'b0, 32'h0);
    push_exp("jal_a", 32'h200, 16'd23, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 26'hC0, 1'b0, 32'h0);
    push_exp("jal_b", 32'h300, 16'd24, 3'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 26'h0, 1'b1, 32'h007);
    push_exp("jr_wrong", 32'h004, 16'd25, 3'd1, 1'b1, 1'b1);
    tick();
    reset_n = 1'b0;
    idle();
    #2;
    push_exp("reset_mid", RV, 16'd0, 3'd0, 1'b0, 1'b0);
    compare_front();
    reset_n = 1'b1;
    push_exp("post_reset", RV + 32'd4, 16'd0, 3'd0, 1'b0, 1'b0);
    tick();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
